// File: rtl/eth_rx_pkg.sv
// Shared constants and types for the Ethernet receive path.
// CRC-32 constants are also used by the transmit side.
package eth_rx_pkg;

  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [47:0] ETH_BCAST    = 48'hFFFF_FFFF_FFFF;

  localparam int LEN_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    PAY,
    DROP
  } rx_state_e;

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rx_frame_crc32_d8.sv
// Byte-wide reflected CRC-32 next-state function.
// Purely combinational so the TX path can share it.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0])
        crc_out = (crc_out >> 1) ^ CRC32_POLY_REFL;
      else
        crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/eth_rx_frame.sv
// RX frame parser: preamble/SFD strip, CRC/length/address/PHY
// checks, FCS strip through a 4-byte delay line, frame counters.
module eth_rx_frame
  import eth_rx_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR  = 48'h0200_0000_0001,
  parameter bit          PROMISC   = 1'b0,
  parameter int          MIN_FRAME = 64,
  parameter int          MAX_FRAME = 1518
) (
  input  logic        clk125MHz,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_en,
  input  logic        rx_err,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_eof,
  output logic        m_good,
  output logic        m_err_crc,
  output logic        m_err_len,
  output logic        m_err_phy,
  output logic        m_addr_ok,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_bad
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  rx_state_e        state;
  logic             armed;
  logic [31:0]      crc;
  logic [31:0]      crc_nx;
  logic [3:0][7:0]  dl;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_inc;
  logic             mac_hit;
  logic             bc_hit;
  logic             phy_seen;
  logic             ovf;
  logic [7:0]       mac_b;
  logic             crc_bad;
  logic             len_bad;
  logic             addr_ok;
  logic             good;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (rx_data),
    .crc_out (crc_nx)
  );

  assign len_inc = (len == LEN_SAT) ? len : len + 1'b1;
  assign crc_bad = (crc != CRC32_RESIDUE);
  assign len_bad = (len < MIN_L) || (len > MAX_L);
  assign addr_ok = PROMISC || mac_hit || bc_hit;
  assign good    = !crc_bad && !len_bad && !phy_seen && addr_ok;

  always_comb begin
    mac_b = 8'h00;
    for (int i = 0; i < 6; i++)
      if (len == LEN_W'(i))
        mac_b = MAC_ADDR[8*(5-i) +: 8];
  end

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      crc       <= CRC32_INIT;
      dl        <= '0;
      len       <= '0;
      mac_hit   <= 1'b0;
      bc_hit    <= 1'b0;
      phy_seen  <= 1'b0;
      ovf       <= 1'b0;
      m_data    <= 8'h00;
      m_valid   <= 1'b0;
      m_sof     <= 1'b0;
      m_eof     <= 1'b0;
      m_good    <= 1'b0;
      m_err_crc <= 1'b0;
      m_err_len <= 1'b0;
      m_err_phy <= 1'b0;
      m_addr_ok <= 1'b0;
      cnt_ok    <= '0;
      cnt_bad   <= '0;
    end else begin
      m_valid   <= 1'b0;
      m_sof     <= 1'b0;
      m_eof     <= 1'b0;
      m_good    <= 1'b0;
      m_err_crc <= 1'b0;
      m_err_len <= 1'b0;
      m_err_phy <= 1'b0;
      m_addr_ok <= 1'b0;
      if (!rx_en)
        armed <= 1'b1;

      unique case (state)
        IDLE: begin
          if (rx_en) begin
            crc      <= CRC32_INIT;
            len      <= '0;
            mac_hit  <= 1'b1;
            bc_hit   <= 1'b1;
            phy_seen <= 1'b0;
            ovf      <= 1'b0;
            // a frame already in flight at reset release is skipped
            if (!armed)
              state <= DROP;
            else if (rx_data == ETH_PREAMBLE)
              state <= PRE;
            else if (rx_data == ETH_SFD)
              state <= PAY;
            else begin
              state   <= DROP;
              cnt_bad <= sat16(cnt_bad);
            end
          end
        end

        PRE: begin
          if (!rx_en) begin
            state   <= IDLE;
            cnt_bad <= sat16(cnt_bad);
          end else if (rx_data == ETH_SFD) begin
            state <= PAY;
          end else if (rx_data != ETH_PREAMBLE) begin
            state   <= DROP;
            cnt_bad <= sat16(cnt_bad);
          end
        end

        PAY: begin
          if (rx_en) begin
            if (len >= MAX_L) begin
              state <= DROP;
              ovf   <= 1'b1;
            end else begin
              crc <= crc_nx;
              dl  <= {dl[2:0], rx_data};
              len <= len_inc;
              if (rx_err)
                phy_seen <= 1'b1;
              if (len < LEN_W'(6)) begin
                if (rx_data != mac_b)
                  mac_hit <= 1'b0;
                if (rx_data != ETH_BCAST[7:0])
                  bc_hit <= 1'b0;
              end
              if (len >= LEN_W'(4)) begin
                m_valid <= 1'b1;
                m_data  <= dl[3];
                m_sof   <= (len == LEN_W'(4));
              end
            end
          end else begin
            state <= IDLE;
            if (len < LEN_W'(5)) begin
              cnt_bad <= sat16(cnt_bad);
            end else begin
              m_eof     <= 1'b1;
              m_good    <= good;
              m_err_crc <= crc_bad;
              m_err_len <= len_bad;
              m_err_phy <= phy_seen;
              m_addr_ok <= addr_ok;
              if (good)
                cnt_ok <= sat16(cnt_ok);
              else
                cnt_bad <= sat16(cnt_bad);
            end
          end
        end

        DROP: begin
          if (!rx_en) begin
            state <= IDLE;
            ovf   <= 1'b0;
            if (ovf) begin
              m_eof     <= 1'b1;
              m_err_len <= 1'b1;
              m_err_phy <= phy_seen;
              m_addr_ok <= addr_ok;
              cnt_bad   <= sat16(cnt_bad);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_frame.sv
// Directed bench for eth_rx_frame: good/bad frames, length limits,
// preamble faults, address filter, back-to-back and mid-frame reset.
module tb_eth_rx_frame;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_en;
  logic        rx_err;

  logic [7:0]  m_data, p_data;
  logic        m_valid, m_sof, m_eof, m_good;
  logic        m_err_crc, m_err_len, m_err_phy, m_addr_ok;
  logic        p_valid, p_sof, p_eof, p_good;
  logic        p_err_crc, p_err_len, p_err_phy, p_addr_ok;
  logic [15:0] cnt_ok, cnt_bad, p_cnt_ok, p_cnt_bad;

  eth_rx_frame u_dut (
    .clk125MHz (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_en     (rx_en),
    .rx_err    (rx_err),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_sof     (m_sof),
    .m_eof     (m_eof),
    .m_good    (m_good),
    .m_err_crc (m_err_crc),
    .m_err_len (m_err_len),
    .m_err_phy (m_err_phy),
    .m_addr_ok (m_addr_ok),
    .cnt_ok    (cnt_ok),
    .cnt_bad   (cnt_bad)
  );

  eth_rx_frame #(.PROMISC(1'b1)) u_prom (
    .clk125MHz (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_en     (rx_en),
    .rx_err    (rx_err),
    .m_data    (p_data),
    .m_valid   (p_valid),
    .m_sof     (p_sof),
    .m_eof     (p_eof),
    .m_good    (p_good),
    .m_err_crc (p_err_crc),
    .m_err_len (p_err_len),
    .m_err_phy (p_err_phy),
    .m_addr_ok (p_addr_ok),
    .cnt_ok    (p_cnt_ok),
    .cnt_bad   (p_cnt_bad)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] ST1 = 48'h0200_0000_0001;
  localparam logic [47:0] ST2 = 48'h0200_0000_0002;

  int ntot  = 0;
  int nfail = 0;

  logic [7:0] frm[$];
  logic [7:0] got[$];
  logic [4:0] ev[$];
  logic [4:0] pv[$];
  int sofs, sofp, badeof;

  // {good, crc, len, phy, addr}
  always @(negedge clk) begin
    if (m_valid) begin
      if (m_sof) begin
        sofs++;
        sofp = got.size();
      end
      got.push_back(m_data);
    end
    if (m_eof) begin
      ev.push_back({m_good, m_err_crc, m_err_len, m_err_phy, m_addr_ok});
      if (m_valid) badeof++;
    end
    if (p_eof)
      pv.push_back({p_good, p_err_crc, p_err_len, p_err_phy, p_addr_ok});
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    got.delete();
    ev.delete();
    pv.delete();
    sofs = 0;
    sofp = -1;
  endtask

  // MSB-first CRC on the normal polynomial, bits fed LSB first
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    logic [31:0] r;
    logic fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) begin
        fb = c[31] ^ frm[i][j];
        c = c << 1;
        if (fb) c = c ^ 32'h04C1_1DB7;
      end
    for (int k = 0; k < 32; k++) r[k] = c[31-k];
    return ~r;
  endfunction

  task automatic build(input logic [47:0] da, input int n);
    logic [31:0] f;
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(da[8*i +: 8]);
    frm.push_back(8'h02);
    for (int i = 0; i < 4; i++) frm.push_back(8'h00);
    frm.push_back(8'hAA);
    frm.push_back(8'h08);
    frm.push_back(8'h00);
    while (frm.size() < n - 4) frm.push_back(8'(frm.size() * 7 + 3));
    f = fcs_of(n - 4);
    for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
  endtask

  task automatic drive(input logic [7:0] b, input logic e);
    rx_en = 1'b1;
    rx_data = b;
    rx_err = e;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    rx_en = 1'b0;
    rx_err = 1'b0;
    rx_data = 8'h00;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int errix);
    repeat (7) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    foreach (frm[i]) drive(frm[i], 1'(i == errix));
    gap(1);
  endtask

  function automatic int mism();
    int m = 0;
    foreach (got[i]) if (got[i] !== frm[i]) m++;
    return m;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    badeof = 0;
    clr();
    rst_n = 1'b0;
    rx_en = 1'b0;
    rx_err = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_eof", 32'(m_eof), 0);
    chk("rst_cnt_ok", 32'(cnt_ok), 0);
    chk("rst_cnt_bad", 32'(cnt_bad), 0);
    rst_n = 1'b1;
    gap(2);

    // good 64-byte broadcast frame
    clr();
    build(BC, 64);
    send(-1);
    gap(3);
    chk("good_nbytes", 32'(got.size()), 60);
    chk("good_data", 32'(mism()), 0);
    chk("good_sofs", 32'(sofs), 1);
    chk("good_sofpos", 32'(sofp), 0);
    chk("good_neof", 32'(ev.size()), 1);
    chk("good_flags", 32'(ev[0]), 32'h11);
    chk("good_cnt_ok", 32'(cnt_ok), 1);

    // one payload bit flipped after the FCS was computed
    clr();
    frm[20] = frm[20] ^ 8'h08;
    send(-1);
    gap(3);
    chk("crc_nbytes", 32'(got.size()), 60);
    chk("crc_data", 32'(mism()), 0);
    chk("crc_flags", 32'(ev[0]), 32'h09);
    chk("crc_cnt_bad", 32'(cnt_bad), 1);

    // 1519-byte frame, correct FCS
    clr();
    build(BC, 1519);
    send(-1);
    gap(3);
    chk("long_nbytes", 32'(got.size()), 1514);
    chk("long_data", 32'(mism()), 0);
    chk("long_neof", 32'(ev.size()), 1);
    chk("long_errlen", 32'(ev[0][2]), 1);
    chk("long_good", 32'(ev[0][4]), 0);
    chk("long_cnt_bad", 32'(cnt_bad), 2);

    // 63-byte frame
    clr();
    build(BC, 63);
    send(-1);
    gap(3);
    chk("short_nbytes", 32'(got.size()), 59);
    chk("short_flags", 32'(ev[0]), 32'h05);
    chk("short_cnt_bad", 32'(cnt_bad), 3);

    // preamble violation
    clr();
    drive(8'h55, 1'b0);
    drive(8'h55, 1'b0);
    drive(8'hA7, 1'b0);
    for (int i = 0; i < 10; i++) drive(8'(i + 8'h40), 1'b0);
    gap(3);
    chk("pre_nbytes", 32'(got.size()), 0);
    chk("pre_neof", 32'(ev.size()), 0);
    chk("pre_cnt_bad", 32'(cnt_bad), 4);

    // 3 payload bytes
    clr();
    repeat (7) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    drive(8'h11, 1'b0);
    drive(8'h22, 1'b0);
    drive(8'h33, 1'b0);
    gap(3);
    chk("tiny_nbytes", 32'(got.size()), 0);
    chk("tiny_neof", 32'(ev.size()), 0);
    chk("tiny_cnt_bad", 32'(cnt_bad), 5);

    // station address, then a foreign one
    clr();
    build(ST1, 64);
    send(-1);
    build(ST2, 64);
    send(-1);
    gap(3);
    chk("addr_neof", 32'(ev.size()), 2);
    chk("addr_st1", 32'(ev[0]), 32'h11);
    chk("addr_st2", 32'(ev[1]), 32'h00);
    chk("addr_cnt_ok", 32'(cnt_ok), 2);
    chk("addr_cnt_bad", 32'(cnt_bad), 6);
    chk("prom_neof", 32'(pv.size()), 2);
    chk("prom_st1", 32'(pv[0]), 32'h11);
    chk("prom_st2", 32'(pv[1]), 32'h11);

    // back-to-back, PHY error on byte 20 of the second
    clr();
    build(BC, 80);
    send(-1);
    send(20);
    gap(3);
    chk("b2b_neof", 32'(ev.size()), 2);
    chk("b2b_first", 32'(ev[0]), 32'h11);
    chk("b2b_second", 32'(ev[1]), 32'h03);
    chk("b2b_cnt_ok", 32'(cnt_ok), 3);
    chk("b2b_cnt_bad", 32'(cnt_bad), 7);

    // reset in the middle of a frame
    repeat (7) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) drive(frm[i], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(m_valid), 0);
    chk("mrst_cnt_ok", 32'(cnt_ok), 0);
    chk("mrst_cnt_bad", 32'(cnt_bad), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    for (int i = 30; i < frm.size(); i++) drive(frm[i], 1'b0);
    gap(3);
    chk("mrst_nbytes", 32'(got.size()), 0);
    chk("mrst_neof", 32'(ev.size()), 0);
    chk("mrst_after_bad", 32'(cnt_bad), 0);

    clr();
    build(BC, 64);
    send(-1);
    gap(3);
    chk("post_nbytes", 32'(got.size()), 60);
    chk("post_flags", 32'(ev[0]), 32'h11);
    chk("post_cnt_ok", 32'(cnt_ok), 1);
    chk("eof_no_valid", 32'(badeof), 0);

    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end

endmodule
